// File: rtl/seq_pkg.sv
// +----------------------------------------------------------------------------+
// | seq_pkg : shared types and helpers for the seq_detect_sched slice          |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package seq_pkg;

  localparam int DEF_PAT_W = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1001;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } ch_state_t;

  // Channel index width; a single channel still gets one bit.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_rr_arb.sv
// +----------------------------------------------------------------------------+
// | seq_rr_arb : round-robin one-hot arbiter with its own rotating pointer     |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_rr_arb
  import seq_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] gnt
);

  localparam int CH_W = ch_w(N_CH);

  logic [CH_W-1:0] r_ptr;
  logic [CH_W-1:0] w_ptr_nxt;
  logic            w_found;

  // Scan offsets from the pointer; the first requesting channel wins.
  always_comb begin
    gnt       = '0;
    w_found   = 1'b0;
    w_ptr_nxt = r_ptr;
    for (int i = 0; i < N_CH; i++) begin
      for (int j = 0; j < N_CH; j++) begin
        if (en && !w_found && req[j] && (j == ((int'(r_ptr) + i) % N_CH))) begin
          gnt[j]    = 1'b1;
          w_found   = 1'b1;
          w_ptr_nxt = CH_W'((j + 1) % N_CH);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_detect_sched.sv
// +----------------------------------------------------------------------------+
// | seq_detect_sched : one pattern matcher time-shared over N_CH bit streams   |
// | Optional per-channel hit counters when HIT_COUNT_EN is defined.            |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_detect_sched
  import seq_pkg::*;
#(
  parameter int               N_CH    = 4,
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               CNT_W   = 8,
  localparam int              CH_W    = ch_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [N_CH-1:0]       ch_valid,
  input  logic [N_CH-1:0]       ch_bit,
  output logic [N_CH-1:0]       ch_ready,
  output logic                  hit_valid,
  output logic [CH_W-1:0]       hit_ch,
  output logic [N_CH*CNT_W-1:0] hit_cnt
);

  localparam int                FILL_W      = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] c_fill_full = FILL_W'(PAT_W);

  logic [N_CH-1:0] w_gnt;
  logic [N_CH-1:0] w_match;
  logic            w_arb_en;
  logic [CH_W-1:0] w_hit_idx;
  logic            r_hit_valid;
  logic [CH_W-1:0] r_hit_ch;

  assign w_arb_en = ~clear;

  seq_rr_arb #(
    .N_CH (N_CH)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .en  (w_arb_en),
    .req (ch_valid),
    .gnt (w_gnt)
  );

  assign ch_ready = w_gnt;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ch_state_t         r_state;
    ch_state_t         w_state_nxt;
    logic [PAT_W-1:0]  r_hist;
    logic [PAT_W-1:0]  w_hist_nxt;
    logic [FILL_W-1:0] r_fill;
    logic [FILL_W-1:0] w_fill_inc;

    assign w_hist_nxt = {r_hist[PAT_W-2:0], ch_bit[c]};
    assign w_fill_inc = (r_fill == c_fill_full) ? c_fill_full : r_fill + FILL_W'(1);

    always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
        w_state_nxt = ST_FILL;
      end else if (w_gnt[c] && (w_fill_inc == c_fill_full)) begin
        w_state_nxt = ST_ARMED;
      end
    end

    // Only a channel that is armed after this bit can match, so reset zeros never alias the pattern.
    assign w_match[c] = w_gnt[c] && (w_state_nxt == ST_ARMED) && (w_hist_nxt == PATTERN);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state <= ST_FILL;
        r_hist  <= '0;
        r_fill  <= '0;
      end else if (clear) begin
        r_state <= ST_FILL;
        r_hist  <= '0;
        r_fill  <= '0;
      end else begin
        r_state <= w_state_nxt;
        if (w_gnt[c]) begin
          r_hist <= w_hist_nxt;
          r_fill <= w_fill_inc;
        end
      end
    end

`ifdef HIT_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt <= '0;
      end else if (clear) begin
        r_cnt <= '0;
      end else if (w_match[c] && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign hit_cnt[c*CNT_W +: CNT_W] = r_cnt;
`else
    assign hit_cnt[c*CNT_W +: CNT_W] = '0;
`endif
  end

  // Grants are one-hot, so at most one channel matches per cycle.
  always_comb begin
    w_hit_idx = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (w_match[c]) begin
        w_hit_idx = CH_W'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_valid <= 1'b0;
      r_hit_ch    <= '0;
    end else begin
      r_hit_valid <= |w_match;
      if (|w_match) begin
        r_hit_ch <= w_hit_idx;
      end
    end
  end

  assign hit_valid = r_hit_valid;
  assign hit_ch    = r_hit_ch;

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_sched.sv
// +----------------------------------------------------------------------------+
// | tb_seq_detect_sched : scoreboard bench with a bit-stream reference model   |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seq_detect_sched;

  localparam int N       = 4;
  localparam int PW      = 4;
  localparam int CW      = 8;
  localparam int CHW     = 2;
  localparam int PAT_VAL = 9;
  localparam int CMAX    = (1 << CW) - 1;

  logic            clk      = 1'b0;
  logic            rst      = 1'b0;
  logic            clear    = 1'b0;
  logic [N-1:0]    ch_valid = '0;
  logic [N-1:0]    ch_bit   = '0;
  logic [N-1:0]    ch_ready;
  logic            hit_valid;
  logic [CHW-1:0]  hit_ch;
  logic [N*CW-1:0] hit_cnt;

  seq_detect_sched #(
    .N_CH  (N),
    .PAT_W (PW),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .ch_valid  (ch_valid),
    .ch_bit    (ch_bit),
    .ch_ready  (ch_ready),
    .hit_valid (hit_valid),
    .hit_ch    (hit_ch),
    .hit_cnt   (hit_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    int due;
    int ch;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  // Reference model: each channel's recent bits as an integer, plus bits seen since clear.
  int mptr;
  int mhist [N];
  int mcount[N];
  int mcnt  [N];
  int last_ch = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_cnt(input int c);
`ifdef HIT_COUNT_EN
    return mcnt[c];
`else
    return 0;
`endif
  endfunction

  task automatic model_clear();
    mptr = 0;
    for (int c = 0; c < N; c++) begin
      mhist[c]  = 0;
      mcount[c] = 0;
      mcnt[c]   = 0;
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] b, input logic clr);
    int   g;
    exp_t e;
    g = -1;
    @(posedge clk);
    #1;
    ch_valid = v;
    ch_bit   = b;
    clear    = clr;
    @(negedge clk);
    if (!clr) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (mptr + i) % N;
        if (g < 0 && v[c]) g = c;
      end
    end
    chk("ch_ready", int'(ch_ready), (g < 0) ? 0 : (1 << g));
    if (clr) begin
      model_clear();
    end else if (g >= 0) begin
      mhist[g] = (mhist[g] * 2 + int'(b[g])) % (1 << PW);
      mcount[g]++;
      mptr = (g + 1) % N;
      if (mcount[g] >= PW && mhist[g] == PAT_VAL) begin
        e.due = cyc + 1;
        e.ch  = g;
        q.push_back(e);
        if (mcnt[g] < CMAX) mcnt[g]++;
      end
    end
  endtask

  // Called right after a step, before the next edge: the pending inputs never get committed.
  task automatic async_reset();
    #2;
    ch_valid = '0;
    clear    = 1'b0;
    rst      = 1'b0;
    #1;
    chk("rst_hit_valid", int'(hit_valid), 0);
    chk("rst_hit_ch", int'(hit_ch), 0);
    for (int c = 0; c < N; c++) chk("rst_hit_cnt", int'(hit_cnt[c*CW +: CW]), 0);
    q.delete();
    model_clear();
    last_ch = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send0(input logic b);
    step(4'b0001, {3'b000, b}, 1'b0);
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #3;
      if (rst) begin
        if (hit_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_hit", 1, 0);
          end else begin
            mon_e = q.pop_front();
            chk("hit_ch", int'(hit_ch), mon_e.ch);
            chk("hit_cycle", cyc, mon_e.due);
            last_ch = mon_e.ch;
          end
        end else begin
          if (q.size() > 0 && q[0].due <= cyc) begin
            chk("missing_hit", 0, 1);
            void'(q.pop_front());
          end
          chk("hit_ch_hold", int'(hit_ch), last_ch);
        end
        for (int c = 0; c < N; c++) chk("hit_cnt", int'(hit_cnt[c*CW +: CW]), exp_cnt(c));
      end
    end
  end

  initial begin : driver
    logic [3:0] rb;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hit_valid", int'(hit_valid), 0);
    chk("reset_hit_ch", int'(hit_ch), 0);
    chk("reset_hit_cnt", int'(hit_cnt), 0);
    @(negedge clk);
    rst = 1'b1;

    // Fresh channel: 0,0,1 must not match; then 0,0,1 completes 1001.
    send0(0); send0(0); send0(1);
    send0(0); send0(0); send0(1);

    // Overlapping matches on ch0.
    step('0, '0, 1'b1);
    send0(1); send0(0); send0(0); send0(1); send0(0); send0(0); send0(1);

    // All channels valid: rotation 0..3, each channel sees 1,0,0,1.
    step('0, '0, 1'b1);
    rb = 4'b1001;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) step(4'hF, {4{rb[3-r]}}, 1'b0);
    end

    // Context retained across idle; no false hit on ch2.
    step('0, '0, 1'b1);
    step(4'b0010, 4'b0010, 1'b0);
    step(4'b0010, 4'b0000, 1'b0);
    rb = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] s;
      s = 8'b10001100;
      step(4'b0100, {1'b0, s[7-k], 2'b00}, 1'b0);
    end
    step(4'b0010, 4'b0000, 1'b0);
    step(4'b0010, 4'b0010, 1'b0);

    // Clear mid-stream, with ch0 still requesting.
    send0(1); send0(0); send0(0);
    step(4'b0001, 4'b0001, 1'b1);
    send0(1);

    // Randomized traffic with occasional clears.
    for (int k = 0; k < 1500; k++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ($urandom_range(0, 49) == 0));
    end

    // Enough overlapping hits on ch0 to saturate an 8-bit counter.
    step('0, '0, 1'b1);
    send0(1);
    for (int k = 0; k < CMAX + 5; k++) begin
      send0(0); send0(0); send0(1);
    end
    send0(0); send0(0); send0(1);
    async_reset();
    send0(1); send0(0); send0(0); send0(1);
    step(4'b1000, 4'b1000, 1'b0);

    repeat (3) step('0, '0, 1'b0);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire
